// File: rtl/sdc_dq_datapath_pkg.sv
// Shared constants for the SDRAM controller DQ datapath: data width,
// default burst/CAS settings and the 3-bit FSM state encodings.
package sdc_dq_datapath_pkg;

    localparam int SDC_DATA_MSB = 31;
    localparam int SDC_DQ_BL    = 4;
    localparam int SDC_DQ_CL    = 2;

    localparam logic [2:0] SDC_DQ_ST_IDLE  = 3'd0;
    localparam logic [2:0] SDC_DQ_ST_WPRE  = 3'd1;
    localparam logic [2:0] SDC_DQ_ST_WDATA = 3'd2;
    localparam logic [2:0] SDC_DQ_ST_WPOST = 3'd3;
    localparam logic [2:0] SDC_DQ_ST_RWAIT = 3'd4;
    localparam logic [2:0] SDC_DQ_ST_RDATA = 3'd5;

endpackage

// File: rtl/sdc_dq_rd_capture.sv
// Read-capture path: samples pad data while i_samp_en is high and returns it with a valid strobe.
// SDC_DQ_RD_REG_EN adds a pad input register, delaying rd_data/rd_valid by one cycle.
module sdc_dq_rd_capture #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_samp_en,
    input  logic [DW-1:0] i_dq,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid
);

    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

`ifdef SDC_DQ_RD_REG_EN
    logic [DW-1:0] r_dq_in_q;
    logic          r_en_q;

    // Pad is still sampled in the RDATA cycles; only the hand-off is one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq_in_q  <= '0;
            r_en_q     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_dq_in_q  <= i_dq;
            r_en_q     <= i_samp_en;
            r_rd_valid <= r_en_q;
            if (r_en_q)
                r_rd_data <= r_dq_in_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_samp_en;
            if (i_samp_en)
                r_rd_data <= i_dq;
        end
    end
`endif

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/sdc_dq_datapath.sv
// DQ-side datapath of the SDRAM controller: write bursts from an FWFT FIFO with
// pre/postamble onto the pads, and CL-delayed read capture (see sdc_dq_rd_capture).
module sdc_dq_datapath
    import sdc_dq_datapath_pkg::*;
#(
    parameter int DW = SDC_DATA_MSB + 1,
    parameter int BL = SDC_DQ_BL,
    parameter int CL = SDC_DQ_CL
) (
    input  logic          sdc_clk,
    input  logic          sdc_rst_n,
    input  logic          wr_start,
    input  logic [DW-1:0] wr_data,
    output logic          wr_data_req,
    input  logic          rd_start,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic [DW-1:0] sdc_dq_o,
    output logic [DW-1:0] sdc_dq_t,
    input  logic [DW-1:0] sdc_dq_i
);

    localparam logic [2:0] LP_BL_LAST = 3'(BL - 1);
    localparam logic [2:0] LP_CL_LAST = (CL > 1) ? 3'(CL - 2) : 3'd0;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [2:0]    r_cnt;
    logic [DW-1:0] r_dq_o;
    logic [DW-1:0] r_dq_t;
    logic          w_samp_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            SDC_DQ_ST_IDLE: begin
                if (wr_start)
                    w_next = SDC_DQ_ST_WPRE;
                else if (rd_start)
                    w_next = (CL > 1) ? SDC_DQ_ST_RWAIT : SDC_DQ_ST_RDATA;
            end
            SDC_DQ_ST_WPRE:  w_next = SDC_DQ_ST_WDATA;
            SDC_DQ_ST_WDATA: if (r_cnt == LP_BL_LAST) w_next = SDC_DQ_ST_WPOST;
            SDC_DQ_ST_WPOST: w_next = SDC_DQ_ST_IDLE;
            SDC_DQ_ST_RWAIT: if (r_cnt == LP_CL_LAST) w_next = SDC_DQ_ST_RDATA;
            SDC_DQ_ST_RDATA: if (r_cnt == LP_BL_LAST) w_next = SDC_DQ_ST_IDLE;
            default:         w_next = SDC_DQ_ST_IDLE;
        endcase
    end

    // Counter restarts on every state change so it counts beats/wait cycles per state.
    always_ff @(posedge sdc_clk or negedge sdc_rst_n) begin
        if (!sdc_rst_n) begin
            r_state <= SDC_DQ_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == SDC_DQ_ST_IDLE)
                r_cnt <= 3'd0;
            else
                r_cnt <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge sdc_clk or negedge sdc_rst_n) begin
        if (!sdc_rst_n) begin
            r_dq_o <= '0;
            r_dq_t <= '1;
        end else begin
            case (r_state)
                SDC_DQ_ST_WPRE: begin
                    r_dq_o <= '0;
                    r_dq_t <= '0;
                end
                SDC_DQ_ST_WDATA: r_dq_o <= wr_data;
                SDC_DQ_ST_WPOST: r_dq_t <= '1;
                default: ;
            endcase
        end
    end

    assign w_samp_en   = (r_state == SDC_DQ_ST_RDATA);
    assign wr_data_req = (r_state == SDC_DQ_ST_WDATA);
    assign busy        = (r_state != SDC_DQ_ST_IDLE);
    assign sdc_dq_o    = r_dq_o;
    assign sdc_dq_t    = r_dq_t;

    sdc_dq_rd_capture #(.DW(DW)) u_rd_capture (
        .clk        (sdc_clk),
        .rst_n      (sdc_rst_n),
        .i_samp_en  (w_samp_en),
        .i_dq       (sdc_dq_i),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_sdc_dq_datapath.sv
// Directed bench for sdc_dq_datapath: default (BL4/CL2), BL8/CL1 and BL2 instances.
module tb_sdc_dq_datapath;

    localparam int RX =
`ifdef SDC_DQ_RD_REG_EN
        1;
`else
        0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] dq_i;

    // instance A: BL=4, CL=2
    logic        wr_start_a, rd_start_a, wr_req_a, rd_valid_a, busy_a;
    logic [31:0] wr_data_a, rd_data_a, dq_o_a, dq_t_a;
    // instance C: BL=8, CL=1
    logic        wr_start_c, rd_start_c, wr_req_c, rd_valid_c, busy_c;
    logic [31:0] wr_data_c, rd_data_c, dq_o_c, dq_t_c;
    // instance B: BL=2, CL=2
    logic        wr_start_b, rd_start_b, wr_req_b, rd_valid_b, busy_b;
    logic [31:0] wr_data_b, rd_data_b, dq_o_b, dq_t_b;

    logic [31:0] fifo_a [0:7];
    logic [2:0]  ptr_a;
    logic [31:0] ptr_b;
    logic [31:0] exp_o  [0:5];

    int n_chk;
    int n_fail;

    sdc_dq_datapath u_dut_a (
        .sdc_clk(clk), .sdc_rst_n(rst_n), .wr_start(wr_start_a), .wr_data(wr_data_a),
        .wr_data_req(wr_req_a), .rd_start(rd_start_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .sdc_dq_o(dq_o_a), .sdc_dq_t(dq_t_a), .sdc_dq_i(dq_i)
    );

    sdc_dq_datapath #(.BL(8), .CL(1)) u_dut_c (
        .sdc_clk(clk), .sdc_rst_n(rst_n), .wr_start(wr_start_c), .wr_data(wr_data_c),
        .wr_data_req(wr_req_c), .rd_start(rd_start_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
        .busy(busy_c), .sdc_dq_o(dq_o_c), .sdc_dq_t(dq_t_c), .sdc_dq_i(dq_i)
    );

    sdc_dq_datapath #(.BL(2), .CL(2)) u_dut_b (
        .sdc_clk(clk), .sdc_rst_n(rst_n), .wr_start(wr_start_b), .wr_data(wr_data_b),
        .wr_data_req(wr_req_b), .rd_start(rd_start_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .sdc_dq_o(dq_o_b), .sdc_dq_t(dq_t_b), .sdc_dq_i(dq_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO models: head word presented continuously, popped on each req edge
    assign wr_data_a = fifo_a[ptr_a];
    assign wr_data_b = 32'hC0 + ptr_b;
    assign wr_data_c = 32'h0;

    always @(posedge clk) begin
        if (wr_req_a) ptr_a <= ptr_a + 3'd1;
        if (wr_req_b) ptr_b <= ptr_b + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // advance to the next cycle; inputs are set and outputs checked 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        ptr_a = 3'd0; ptr_b = 32'd0;
        fifo_a[0] = 32'h11; fifo_a[1] = 32'h22; fifo_a[2] = 32'h33; fifo_a[3] = 32'h44;
        fifo_a[4] = 32'h55; fifo_a[5] = 32'h66; fifo_a[6] = 32'h77; fifo_a[7] = 32'h88;
        exp_o[0] = 32'h0;  exp_o[1] = 32'h11; exp_o[2] = 32'h22;
        exp_o[3] = 32'h33; exp_o[4] = 32'h44; exp_o[5] = 32'h44;
        wr_start_a = 0; rd_start_a = 0; wr_start_b = 0; rd_start_b = 0;
        wr_start_c = 0; rd_start_c = 0; dq_i = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.dq_t", dq_t_a, 32'hFFFFFFFF);
        chk("rst.dq_o", dq_o_a, 32'h0);
        chk("rst.rd_valid", {31'd0, rd_valid_a}, 32'd0);
        chk("rst.rd_data", rd_data_a, 32'h0);
        chk("rst.busy", {31'd0, busy_a}, 32'd0);
        chk("rst.wr_req", {31'd0, wr_req_a}, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // write BL4, stray starts while busy, back-to-back read at cycle 7
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) cyc();
            wr_start_a = (k == 0 || k == 3);
            rd_start_a = (k == 4 || k == 7);
            dq_i = (k >= 9 && k <= 12) ? 32'hA0 + 32'(k - 9) : 32'hDEAD0000 + 32'(k);
            chk($sformatf("wr.dq_t k=%0d", k), dq_t_a, (k >= 2 && k <= 6) ? 32'h0 : 32'hFFFFFFFF);
            if (k >= 2 && k <= 7)
                chk($sformatf("wr.dq_o k=%0d", k), dq_o_a, exp_o[k-2]);
            chk($sformatf("wr.req k=%0d", k), {31'd0, wr_req_a}, {31'd0, (k >= 2 && k <= 5)});
            chk($sformatf("b2b.busy k=%0d", k), {31'd0, busy_a},
                {31'd0, ((k >= 1 && k <= 6) || (k >= 8 && k <= 12))});
            chk($sformatf("b2b.rd_valid k=%0d", k), {31'd0, rd_valid_a},
                {31'd0, (k >= 10 + RX && k <= 13 + RX)});
            if (k >= 10 + RX && k <= 13 + RX)
                chk($sformatf("b2b.rd_data k=%0d", k), rd_data_a, 32'hA0 + 32'(k - 10 - RX));
        end
        wr_start_a = 0; rd_start_a = 0;
        cyc(); cyc();

        // collision: write wins, read dropped
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) cyc();
            wr_start_a = (k == 0);
            rd_start_a = (k == 0);
            dq_i = 32'hBAD00000 + 32'(k);
            chk($sformatf("col.rd_valid k=%0d", k), {31'd0, rd_valid_a}, 32'd0);
            chk($sformatf("col.req k=%0d", k), {31'd0, wr_req_a}, {31'd0, (k >= 2 && k <= 5)});
            if (k >= 3 && k <= 6)
                chk($sformatf("col.dq_o k=%0d", k), dq_o_a, 32'h55 + 32'h11 * 32'(k - 3));
        end
        wr_start_a = 0; rd_start_a = 0;
        cyc();

        // asynchronous reset mid-WDATA
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) cyc();
            wr_start_a = (k == 0);
        end
        wr_start_a = 0;
        chk("mid.req_pre", {31'd0, wr_req_a}, 32'd1);
        chk("mid.dq_t_pre", dq_t_a, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.dq_t", dq_t_a, 32'hFFFFFFFF);
        chk("mid.req", {31'd0, wr_req_a}, 32'd0);
        chk("mid.busy", {31'd0, busy_a}, 32'd0);
        chk("mid.dq_o", dq_o_a, 32'h0);
        #1 rst_n = 1'b1;
        cyc();

        // asynchronous reset with rd_valid in flight
        for (int k = 0; k <= 3 + RX; k++) begin
            if (k > 0) cyc();
            rd_start_a = (k == 0);
            dq_i = 32'h5A5A0000 + 32'(k);
        end
        rd_start_a = 0;
        chk("rdrst.valid_pre", {31'd0, rd_valid_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rdrst.valid", {31'd0, rd_valid_a}, 32'd0);
        chk("rdrst.data", rd_data_a, 32'h0);
        chk("rdrst.busy", {31'd0, busy_a}, 32'd0);
        #1 rst_n = 1'b1;
        cyc(); cyc();

        // corners: CL=1/BL=8 read on C, BL=2 write on B
        begin
            int req_cnt;
            req_cnt = 0;
            for (int k = 0; k <= 12; k++) begin
                if (k > 0) cyc();
                rd_start_c = (k == 0);
                wr_start_b = (k == 0);
                dq_i = (k >= 1 && k <= 8) ? 32'hB0 + 32'(k - 1) : 32'hF00D0000 + 32'(k);
                chk($sformatf("c.rd_valid k=%0d", k), {31'd0, rd_valid_c},
                    {31'd0, (k >= 2 + RX && k <= 9 + RX)});
                if (k >= 2 + RX && k <= 9 + RX)
                    chk($sformatf("c.rd_data k=%0d", k), rd_data_c, 32'hB0 + 32'(k - 2 - RX));
                chk($sformatf("c.busy k=%0d", k), {31'd0, busy_c}, {31'd0, (k >= 1 && k <= 8)});
                chk($sformatf("b.req k=%0d", k), {31'd0, wr_req_b}, {31'd0, (k >= 2 && k <= 3)});
                chk($sformatf("b.dq_t k=%0d", k), dq_t_b, (k >= 2 && k <= 4) ? 32'h0 : 32'hFFFFFFFF);
                if (k == 3 || k == 4)
                    chk($sformatf("b.dq_o k=%0d", k), dq_o_b, 32'hC0 + 32'(k - 3));
                if (wr_req_b) req_cnt++;
            end
            chk("b.req_total", 32'(req_cnt), 32'd2);
        end
        rd_start_c = 0; wr_start_b = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
